// File: rtl/cdb_broadcaster.sv
// Common data bus transmit side: two small per-source result queues (add/sub
// and load/store) with an oldest-first arbiter that drives one registered
// {tag, data} broadcast per cycle.
module cdb_broadcaster #(
  parameter int DEPTH  = 2,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 16,
  parameter int AGE_W  = 10
) (
  input  logic                    CLK,
  input  logic                    CLR,
  input  logic                    s0_valid,
  input  logic [TAG_W-1:0]        s0_tag,
  input  logic [3:0]              s0_rd,
  input  logic [DATA_W-1:0]       s0_data,
  input  logic [AGE_W-1:0]        s0_age,
  output logic                    s0_ready,
  input  logic                    s1_valid,
  input  logic [TAG_W-1:0]        s1_tag,
  input  logic [3:0]              s1_rd,
  input  logic [DATA_W-1:0]       s1_data,
  input  logic [AGE_W-1:0]        s1_age,
  output logic                    s1_ready,
  output logic [TAG_W+DATA_W-1:0] cdb,
  output logic                    cdb_valid,
  output logic [3:0]              cdb_rd
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [AGE_W-1:0] HALF = {1'b1, {(AGE_W-1){1'b0}}};

  // Queue storage and bookkeeping, indexed [source][slot]
  logic [TAG_W-1:0]  r_tag  [2][DEPTH];
  logic [3:0]        r_rd   [2][DEPTH];
  logic [DATA_W-1:0] r_data [2][DEPTH];
  logic [AGE_W-1:0]  r_age  [2][DEPTH];
  logic [PW-1:0]     r_wp   [2];
  logic [PW-1:0]     r_rp   [2];
  logic [CW-1:0]     r_cnt  [2];

  logic [TAG_W+DATA_W-1:0] r_cdb;
  logic                    r_cdb_valid;
  logic [3:0]              r_cdb_rd;

  // Per-source views of inputs and heads
  logic              w_in_valid [2];
  logic [TAG_W-1:0]  w_in_tag   [2];
  logic [3:0]        w_in_rd    [2];
  logic [DATA_W-1:0] w_in_data  [2];
  logic [AGE_W-1:0]  w_in_age   [2];
  logic              w_ready    [2];
  logic              w_push     [2];
  logic              w_pop      [2];
  logic              w_ne       [2];
  logic [TAG_W-1:0]  w_hd_tag   [2];
  logic [3:0]        w_hd_rd    [2];
  logic [DATA_W-1:0] w_hd_data  [2];
  logic [AGE_W-1:0]  w_hd_age   [2];

  logic [AGE_W-1:0]  w_age_diff;
  logic              w_s1_older;
  logic              w_sel1;
  logic              w_any;

  // Map the two source port groups onto indexed arrays
  always_comb begin
    w_in_valid[0] = s0_valid;
    w_in_tag[0]   = s0_tag;
    w_in_rd[0]    = s0_rd;
    w_in_data[0]  = s0_data;
    w_in_age[0]   = s0_age;
    w_in_valid[1] = s1_valid;
    w_in_tag[1]   = s1_tag;
    w_in_rd[1]    = s1_rd;
    w_in_data[1]  = s1_data;
    w_in_age[1]   = s1_age;
  end

  // Readiness from registered count only; tag 0 is accepted but never stored
  always_comb begin
    for (int unsigned s = 0; s < 2; s++) begin
      w_ready[s]   = (r_cnt[s] < CW'(DEPTH));
      w_ne[s]      = (r_cnt[s] != '0);
      w_push[s]    = w_in_valid[s] & w_ready[s] & (w_in_tag[s] != '0);
      w_hd_tag[s]  = r_tag[s][r_rp[s]];
      w_hd_rd[s]   = r_rd[s][r_rp[s]];
      w_hd_data[s] = r_data[s][r_rp[s]];
      w_hd_age[s]  = r_age[s][r_rp[s]];
    end
  end

  // Oldest-first arbitration with wrap-aware age compare; ties and the
  // exact half-range distance fall to source 0
  always_comb begin
    w_age_diff = w_hd_age[0] - w_hd_age[1];
    w_s1_older = (w_age_diff != '0) && (w_age_diff < HALF);
    w_sel1     = w_ne[1] && (!w_ne[0] || w_s1_older);
    w_any      = w_ne[0] || w_ne[1];
    w_pop[0]   = w_ne[0] && !w_sel1;
    w_pop[1]   = w_sel1;
  end

  // Entry storage: written at the tail on an accepted, non-zero-tag push
  always_ff @(posedge CLK) begin
    for (int unsigned s = 0; s < 2; s++) begin
      if (w_push[s]) begin
        r_tag[s][r_wp[s]]  <= w_in_tag[s];
        r_rd[s][r_wp[s]]   <= w_in_rd[s];
        r_data[s][r_wp[s]] <= w_in_data[s];
        r_age[s][r_wp[s]]  <= w_in_age[s];
      end
    end
  end

  // Queue pointers and occupancy; clearing discards all held entries
  always_ff @(posedge CLK) begin
    for (int unsigned s = 0; s < 2; s++) begin
      if (CLR) begin
        r_wp[s]  <= '0;
        r_rp[s]  <= '0;
        r_cnt[s] <= '0;
      end else begin
        if (w_push[s]) r_wp[s] <= r_wp[s] + 1'b1;
        if (w_pop[s])  r_rp[s] <= r_rp[s] + 1'b1;
        r_cnt[s] <= r_cnt[s] + CW'(w_push[s]) - CW'(w_pop[s]);
      end
    end
  end

  // Registered broadcast; bus fields hold their last value when idle
  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_cdb       <= '0;
      r_cdb_rd    <= '0;
      r_cdb_valid <= 1'b0;
    end else begin
      r_cdb_valid <= w_any;
      if (w_any) begin
        r_cdb    <= w_sel1 ? {w_hd_tag[1], w_hd_data[1]} : {w_hd_tag[0], w_hd_data[0]};
        r_cdb_rd <= w_sel1 ? w_hd_rd[1] : w_hd_rd[0];
      end
    end
  end

  assign s0_ready  = w_ready[0];
  assign s1_ready  = w_ready[1];
  assign cdb       = r_cdb;
  assign cdb_valid = r_cdb_valid;
  assign cdb_rd    = r_cdb_rd;

endmodule
